// File: rtl/lfsr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_arb_pkg
// Shared definitions for the LFSR-core round-robin scheduler: the core word
// width and the job-sequencing state encoding.
// ---------------------------------------------------------------------------
package lfsr_arb_pkg;

  // Width of the shared Fibonacci LFSR core (state, seed and stop code).
  localparam int LFSR_W = 16;

  // Job sequencing: IDLE (core held in load) -> LOAD (seed captured)
  // -> RUN (words streamed) -> DRAIN (wait for core done) -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

endpackage : lfsr_arb_pkg

// File: rtl/lfsr_arbiter_if.sv
// ---------------------------------------------------------------------------
// lfsr_arbiter_if
// Bundle between the scheduler and the single shared LFSR core.
//   core_load_o  scheduler -> core  core reset; high = load seed, clear counter
//   core_seed_o  scheduler -> core  seed captured while core_load_o is high
//   core_stop_o  scheduler -> core  stop code (core counter limit)
//   core_out_i   core -> scheduler  current core state word
//   core_done_i  core -> scheduler  core reached its stop code
// Signal names are taken from the scheduler's point of view.
// Modports: master = scheduler side, slave = core side.
// ---------------------------------------------------------------------------
interface lfsr_arbiter_if
  import lfsr_arb_pkg::*;
#(
  parameter int W = LFSR_W
);

  logic         core_load_o;
  logic [W-1:0] core_seed_o;
  logic [W-1:0] core_stop_o;
  logic [W-1:0] core_out_i;
  logic         core_done_i;

  modport master (
    output core_load_o,
    output core_seed_o,
    output core_stop_o,
    input  core_out_i,
    input  core_done_i
  );

  modport slave (
    input  core_load_o,
    input  core_seed_o,
    input  core_stop_o,
    output core_out_i,
    output core_done_i
  );

endinterface : lfsr_arbiter_if

// File: rtl/lfsr_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches upward from ptr_i (wrapping
// modulo NREQ) for the first asserted request.
//   req_i    in   NREQ  request vector
//   ptr_i    in   IDW   highest-priority index for this pick
//   gnt_o    out  NREQ  one-hot winner (all zero when no request)
//   id_o     out  IDW   binary index of the winner
//   valid_o  out  1     at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  id_o,
  output logic            valid_o
);

  logic [IDW-1:0] idx_s;
  logic           found_s;

  // Rotating priority search; the first hit from ptr_i upward wins.
  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found_s && req_i[idx_s]) begin
        found_s      = 1'b1;
        gnt_o[idx_s] = 1'b1;
        id_o         = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    valid_o = found_s;
  end

endmodule : rr_arbiter

// File: rtl/lfsr_arbiter.sv
// ---------------------------------------------------------------------------
// lfsr_arbiter
// Round-robin scheduler sharing one 16-bit Fibonacci LFSR core between NREQ
// requesters. A granted job loads its seed by holding the core in load, then
// streams len+1 core words tagged with the requester id, then waits for the
// core's done flag before freeing the core.
//   clk_i        in   1       clock, rising edge
//   nreset_i     in   1       synchronous active-high reset
//   req_i        in   NREQ    job request per requester (level)
//   req_seed_i   in   NREQ*W  seed of requester i at [i*W +: W]
//   req_len_i    in   NREQ*W  stop code of requester i (job = len+1 words)
//   gnt_o        out  NREQ    one-hot grant, held for the whole job
//   busy_o       out  1       scheduler not idle
//   core         if   master  core_load/seed/stop out, core_out/done in
//   rnd_o        out  W       stream word (core state pass-through)
//   rnd_valid_o  out  1       stream word valid
//   rnd_id_o     out  IDW     owner of the current word
//   rnd_last_o   out  1       final word of the job
// ---------------------------------------------------------------------------
module lfsr_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = LFSR_W,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] req_seed_i,
  input  logic [NREQ*W-1:0] req_len_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic              busy_o,
  lfsr_arbiter_if.master    core,
  output logic [W-1:0]      rnd_o,
  output logic              rnd_valid_o,
  output logic [IDW-1:0]    rnd_id_o,
  output logic              rnd_last_o
);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic [IDW-1:0]  ptr_q,   ptr_d;
  logic [IDW-1:0]  id_q,    id_d;
  logic [W-1:0]    seed_q,  seed_d;
  logic [W-1:0]    len_q,   len_d;
  logic [W-1:0]    cnt_q,   cnt_d;

  logic [NREQ-1:0] pick_gnt_s;
  logic [IDW-1:0]  pick_id_s;
  logic            pick_valid_s;
  logic            last_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt_s),
    .id_o    (pick_id_s),
    .valid_o (pick_valid_s)
  );

  // cnt is compared before it is incremented, so len = all-ones never wraps.
  assign last_s = (cnt_q == len_q);

  // Next-state and job-register update for the job sequencer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    seed_d  = seed_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Inputs are sampled only here; everything later uses latched copies.
        if (pick_valid_s) begin
          gnt_d   = pick_gnt_s;
          id_d    = pick_id_s;
          seed_d  = req_seed_i[pick_id_s*W +: W];
          len_d   = req_len_i[pick_id_s*W +: W];
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (last_s) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      DRAIN: begin
        if (core.core_done_i) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (id_q == IDW'(NREQ - 1)) ? IDW'(0) : id_q + IDW'(1);
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and job registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (nreset_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      seed_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode registered state only; req_i never reaches them.
  assign gnt_o            = gnt_q;
  assign busy_o           = (state_q != IDLE);
  assign core.core_load_o = (state_q == IDLE) || (state_q == LOAD);
  assign core.core_seed_o = seed_q;
  assign core.core_stop_o = len_q;
  assign rnd_o            = core.core_out_i;
  assign rnd_valid_o      = (state_q == RUN);
  assign rnd_last_o       = (state_q == RUN) && last_s;
  assign rnd_id_o         = id_q;

endmodule : lfsr_arbiter
